// File: rtl/seg_decode_downcounter.sv
// ---------------------------------------------------------------------------
// seg_decode_downcounter
//
// Reads a byte back from two active-low 7-segment glyphs (HEX1/HEX0 style).
// It then counts that byte down to zero. This is the receiving end of the
// binary->segment display path, used for loop-back checks and countdowns.
//
// State updates on the falling edge of clock, because the clock is KEY-driven.
//
// Ports
//   clock   in   1  system clock, active on the falling edge
//   reset   in   1  synchronous, active-low
//   load    in   1  decode seg_hi/seg_lo into Q; wins over enable
//   enable  in   1  decrement Q once per edge while counting
//   seg_hi  in   7  active-low glyph, upper nibble (bit0=a .. bit6=g)
//   seg_lo  in   7  active-low glyph, lower nibble (bit0=a .. bit6=g)
//   Q       out  8  current count value
//   valid   out  1  Q holds a decoded value (COUNT or DONE)
//   done    out  1  count has reached zero (DONE)
//   err     out  1  last load contained an unrecognised glyph (ERROR)
// ---------------------------------------------------------------------------
module seg_decode_downcounter (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic       enable,
   input  logic [6:0] seg_hi,
   input  logic [6:0] seg_lo,
   output logic [7:0] Q,
   output logic       valid,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2,
      ERROR = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] count_q, count_d;
   logic       valid_q, valid_d;
   logic       done_q,  done_d;
   logic       err_q,   err_d;

   // Returns {ok, nibble}. A glyph is accepted only on an exact match, so
   // partially lit or corrupted patterns are rejected.
   function automatic logic [4:0] glyph_to_nib(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'h40:   r = {1'b1, 4'h0};
         7'h79:   r = {1'b1, 4'h1};
         7'h24:   r = {1'b1, 4'h2};
         7'h30:   r = {1'b1, 4'h3};
         7'h19:   r = {1'b1, 4'h4};
         7'h12:   r = {1'b1, 4'h5};
         7'h02:   r = {1'b1, 4'h6};
         7'h78:   r = {1'b1, 4'h7};
         7'h00:   r = {1'b1, 4'h8};
         7'h10:   r = {1'b1, 4'h9};
         7'h08:   r = {1'b1, 4'hA};
         7'h03:   r = {1'b1, 4'hB};
         7'h46:   r = {1'b1, 4'hC};
         7'h21:   r = {1'b1, 4'hD};
         7'h06:   r = {1'b1, 4'hE};
         7'h0E:   r = {1'b1, 4'hF};
         default: r = 5'b0_0000;
      endcase
      return r;
   endfunction

   logic [4:0] hi_dec, lo_dec;
   logic [7:0] load_val;

   always_comb begin
      hi_dec   = glyph_to_nib(seg_hi);
      lo_dec   = glyph_to_nib(seg_lo);
      load_val = {hi_dec[3:0], lo_dec[3:0]};
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (load) begin
         if (hi_dec[4] && lo_dec[4]) begin
            count_d = load_val;
            state_d = (load_val == 8'h00) ? DONE : COUNT;
         end else begin
            // Keep the old count so the previous value is still inspectable.
            state_d = ERROR;
         end
      end else if (state_q == COUNT && enable) begin
         // Reaching zero moves to DONE on the same edge. Because of this, Q can
         // never wrap from 00 to FF.
         if (count_q <= 8'h01) begin
            count_d = 8'h00;
            state_d = DONE;
         end else begin
            count_d = count_q - 8'h01;
         end
      end
      valid_d = (state_d == COUNT) || (state_d == DONE);
      done_d  = (state_d == DONE);
      err_d   = (state_d == ERROR);
   end

   always_ff @(negedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= 8'h00;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign Q     = count_q;
   assign valid = valid_q;
   assign done  = done_q;
   assign err   = err_q;

endmodule

// File: tb/tb_seg_decode_downcounter.sv
module tb_seg_decode_downcounter;

   logic       clock;
   logic       reset;
   logic       load;
   logic       enable;
   logic [6:0] seg_hi;
   logic [6:0] seg_lo;
   logic [7:0] Q;
   logic       valid;
   logic       done;
   logic       err;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   seg_decode_downcounter dut (
      .clock  (clock),
      .reset  (reset),
      .load   (load),
      .enable (enable),
      .seg_hi (seg_hi),
      .seg_lo (seg_lo),
      .Q      (Q),
      .valid  (valid),
      .done   (done),
      .err    (err)
   );

   initial clock = 1'b1;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One falling (active) edge, then settle before sampling or driving.
   task automatic tick;
      @(negedge clock);
      #1;
   endtask

   task automatic do_load(input logic [6:0] hi, input logic [6:0] lo, input logic en);
      load   = 1'b1;
      enable = en;
      seg_hi = hi;
      seg_lo = lo;
      tick();
      load   = 1'b0;
      $display("load hi=%02h lo=%02h en=%0b -> Q=%02h v=%0b d=%0b e=%0b",
               hi, lo, en, Q, valid, done, err);
   endtask

   // {valid, done, err}
   function automatic logic [31:0] flags();
      return 32'({valid, done, err});
   endfunction

   initial begin
      reset  = 1'b0;
      load   = 1'b1;
      enable = 1'b1;
      seg_hi = 7'h79;
      seg_lo = 7'h30;

      // 1: reset overrides load for two edges
      tick();
      tick();
      check("reset_q", 32'(Q), 32'h00);
      check("reset_flags", flags(), 32'b000);

      // 2: load 0x13, count down to zero
      reset = 1'b1;
      do_load(7'h79, 7'h30, 1'b1);
      check("load13_q", 32'(Q), 32'h13);
      check("load13_flags", flags(), 32'b100);
      for (int i = 1; i <= 19; i++) begin
         tick();
         check("count_q", 32'(Q), 32'(8'h13 - 8'(i)));
         check("count_flags", flags(), (i == 19) ? 32'b110 : 32'b100);
      end
      tick();
      check("hold_zero_q", 32'(Q), 32'h00);
      check("hold_zero_flags", flags(), 32'b110);

      // 3: load zero goes straight to DONE
      do_load(7'h40, 7'h40, 1'b1);
      check("load00_q", 32'(Q), 32'h00);
      check("load00_flags", flags(), 32'b110);
      tick();
      check("no_underflow_q", 32'(Q), 32'h00);

      // 4: invalid glyph keeps Q, then recover with FF
      enable = 1'b0;
      do_load(7'h40, 7'h12, 1'b0);
      check("load05_q", 32'(Q), 32'h05);
      do_load(7'h7F, 7'h40, 1'b0);
      check("err_q", 32'(Q), 32'h05);
      check("err_flags", flags(), 32'b001);
      enable = 1'b1;
      tick();
      check("err_en_q", 32'(Q), 32'h05);
      check("err_en_flags", flags(), 32'b001);
      do_load(7'h0E, 7'h0E, 1'b0);
      check("loadFF_q", 32'(Q), 32'hFF);
      check("loadFF_flags", flags(), 32'b100);
      do_load(7'h40, 7'h7F, 1'b0);
      check("err_lo_flags", flags(), 32'b001);
      check("err_lo_q", 32'(Q), 32'hFF);

      // 5: simultaneous load and enable is a pure load
      do_load(7'h40, 7'h08, 1'b0);
      check("load0A_q", 32'(Q), 32'h0A);
      do_load(7'h24, 7'h19, 1'b1);
      check("load_en_q", 32'(Q), 32'h24);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold24_q", 32'(Q), 32'h24);
      end

      // 6: reset mid-count, then enable alone does nothing
      do_load(7'h00, 7'h40, 1'b1);
      check("load80_q", 32'(Q), 32'h80);
      tick();
      check("dec80_q", 32'(Q), 32'h7F);
      reset = 1'b0;
      tick();
      check("midreset_q", 32'(Q), 32'h00);
      check("midreset_flags", flags(), 32'b000);
      reset  = 1'b1;
      enable = 1'b1;
      tick();
      check("idle_en_q", 32'(Q), 32'h00);
      check("idle_en_flags", flags(), 32'b000);

      // Exhaustive glyph-pair decode
      enable = 1'b0;
      for (int h = 0; h < 16; h++) begin
         for (int l = 0; l < 16; l++) begin
            load   = 1'b1;
            seg_hi = GLYPH[h];
            seg_lo = GLYPH[l];
            tick();
            check("decode_q", 32'(Q), 32'((h << 4) | l));
            check("decode_flags", flags(), (h == 0 && l == 0) ? 32'b110 : 32'b100);
         end
      end
      load = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
